rom_loader: RTL and testbench
=============================

# rom_loader

Boot-time program loader placed directly upstream of the instruction ROM in the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and writes them into the ROM one word per write cycle. After the image is loaded, it asserts the ROM read enable and holds it high, which lets the core fetch by PC.

## Interface
- ADDRESS_BITS, 4: ROM address port is ADDRESS_BITS+1 bits wide; capacity is 2^(ADDRESS_BITS+1) words (32 at default).
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-low; sampled on the rising edge of CLK.
- START  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE and ERROR.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA is valid.
- RX_READY  out  1  loader accepts a byte; a transfer occurs on an edge where RX_VALID and RX_READY are both high.
- W_EN  out  1  ROM write enable.
- W_INSTRUCTION  out  32  word to write.
- ADDRESS  out  ADDRESS_BITS+1  ROM write address.
- R_EN  out  1  ROM read enable; high only in DONE.
- BUSY  out  1  high in HEADER, PAYLOAD, WRITE and CHECK.
- DONE  out  1  high in DONE.
- ERROR  out  1  high in ERROR.

## Operation
- Stream format:
  - header byte N = word count, valid range 1..2^(ADDRESS_BITS+1);
  - then 4N payload bytes, each word least-significant byte first;
  - then one checksum byte, only when the checksum feature is compiled in.
- FSM states: IDLE, HEADER, PAYLOAD, WRITE, CHECK, DONE, ERROR.
- IDLE:
  - START moves the FSM to HEADER.
  - All outputs are low. ADDRESS = 0.
- HEADER:
  - RX_READY = 1.
  - On an accepted byte: if N = 0 or N > capacity, go to ERROR; otherwise latch N, clear the byte and word counters, and go to PAYLOAD.
- PAYLOAD:
  - RX_READY = 1.
  - Each accepted byte is shifted into the packer.
  - On the 4th byte of a word, go to WRITE.
- WRITE (exactly one cycle):
  - W_EN = 1 and RX_READY = 0.
  - ADDRESS = current word index; W_INSTRUCTION = the assembled word.
  - If this is not the last word: return to PAYLOAD and increment ADDRESS.
  - If this is the last word: go to CHECK (feature on) or DONE (feature off). ADDRESS does not increment.
- ROM protection rule: the ROM zeroes REG[ADDRESS] whenever W_EN and R_EN are both low. The loader therefore follows these rules outside WRITE:
  - In IDLE, HEADER and PAYLOAD, ADDRESS points only at a not-yet-written slot.
  - In CHECK, W_EN stays 1 and ADDRESS/W_INSTRUCTION keep re-driving the last word (a harmless rewrite).
- DONE:
  - R_EN = 1 and W_EN = 0; held indefinitely.
  - START returns the FSM to HEADER, dropping R_EN on that edge.
- ERROR:
  - All enables are low; ERROR = 1. The image is invalid, so clearing REG[ADDRESS] here is acceptable.
  - START goes to HEADER.
- START is ignored while BUSY. RX_VALID is ignored while RX_READY = 0.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and all counters and the checksum accumulator are 0.
- Reset has priority over all other inputs. Reset in any state (including mid-load) returns the FSM to IDLE on that edge and drops R_EN and W_EN.
- START registered → HEADER on the next edge, with RX_READY high from that cycle.
- The 4th byte of a word is accepted at edge k → W_EN is high during the cycle after edge k. RX_READY is high again from edge k+1.
- With no stalls, loading N words takes 1 + 5N cycles after HEADER is entered (+1 with the checksum), plus 1 cycle to enter DONE.
- RX_VALID held low stalls indefinitely with no state change.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - After the last WRITE, the FSM enters CHECK with RX_READY = 1.
  - The accepted byte must equal the XOR of the header byte and all payload bytes.
  - Match → DONE; mismatch → ERROR.
- LOADER_CHECKSUM_EN undefined:
  - No CHECK state and no accumulator.
  - The last WRITE goes directly to DONE.

## Structure
- Package rom_loader_pkg holds:
  - the state encoding enum;
  - BYTES_PER_WORD = 4;
  - the capacity function of ADDRESS_BITS.
- Sub-module rom_loader_packer: a 4-byte little-endian shift register with a byte counter and a word_ready pulse.

## Test plan
- N=2, bytes 13 05 00 00 93 05 10 00 → W_EN pulses at ADDRESS 0 (0x00000513) and ADDRESS 1 (0x00100593); then DONE=1, R_EN=1.
- Header 0x00 → ERROR=1 with no W_EN pulse. Header 0x21 (ADDRESS_BITS=4) → ERROR=1.
- RX_VALID toggles every other cycle during PAYLOAD → same writes as the first scenario; RX_READY=0 during each WRITE cycle.
- Assert RST low after 3 payload bytes → next edge is IDLE with all outputs 0. A subsequent START and a full load succeed.
- LOADER_CHECKSUM_EN defined, N=1, word 0x00000013, checksum 0x12 → DONE. The same load with checksum 0x13 → ERROR, and R_EN never rises.
- N=32 → the last write is at ADDRESS 31. In DONE, ADDRESS stays at 31 and word 0 is still intact when read back.

Source files
------------

// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the boot-time ROM loader.
// The optional checksum byte is enabled by defining LOADER_CHECKSUM_EN.
package rom_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_WRITE   = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    // ROM depth in words for a given address parameter (address port is address_bits+1 wide)
    function automatic int unsigned capacity(input int unsigned address_bits);
        return 32'd1 << (address_bits + 32'd1);
    endfunction

endpackage

// File: rtl/rom_loader_packer.sv
// Little-endian byte-to-word packer: first byte of a word ends up in bits [7:0].
module rom_loader_packer
    import rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  cnt_r;
    logic [31:0] word_r;

    // Shift register and byte counter; new bytes enter at the top so the oldest lands at the bottom
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= 2'd0;
            word_r <= 32'd0;
        end else if (clr) begin
            cnt_r <= 2'd0;
        end else if (shift_en) begin
            word_r <= {byte_in, word_r[31:8]};
            cnt_r  <= cnt_r + 2'd1;
        end
    end

    assign word_ready = shift_en && (cnt_r == 2'(BYTES_PER_WORD - 1));
    assign word       = word_r;

endmodule

// File: rtl/rom_loader.sv
// Byte-stream program loader in front of the instruction ROM.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDRESS_BITS = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [7:0]            RX_DATA,
    input  logic                  RX_VALID,
    output logic                  RX_READY,
    output logic                  W_EN,
    output logic [31:0]           W_INSTRUCTION,
    output logic [ADDRESS_BITS:0] ADDRESS,
    output logic                  R_EN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR
);

    localparam int          AW  = ADDRESS_BITS + 1;
    localparam logic [31:0] CAP = 32'(capacity(ADDRESS_BITS));

    state_t          state_r, state_s;
    logic [AW-1:0]   idx_r;
    logic [AW:0]     n_r;
    logic            rx_ready_r, w_en_r, r_en_r, busy_r, done_r, error_r;
    logic            accept_s, hdr_bad_s, last_s, word_ready_s;
    logic [31:0]     word_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum_r;
`endif

    assign accept_s  = RX_VALID && rx_ready_r;
    assign hdr_bad_s = (RX_DATA == 8'd0) || ({24'd0, RX_DATA} > CAP);
    assign last_s    = ({1'b0, idx_r} == (n_r - {{AW{1'b0}}, 1'b1}));

    rom_loader_packer u_packer (
        .clk        (CLK),
        .rst_n      (RST),
        .clr        ((state_r == ST_HEADER) && accept_s),
        .shift_en   ((state_r == ST_PAYLOAD) && accept_s),
        .byte_in    (RX_DATA),
        .word       (word_s),
        .word_ready (word_ready_s)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (START) state_s = ST_HEADER;
                else       state_s = ST_IDLE;
            end
            ST_HEADER: begin
                if (accept_s) state_s = hdr_bad_s ? ST_ERROR : ST_PAYLOAD;
                else          state_s = ST_HEADER;
            end
            ST_PAYLOAD: begin
                if (word_ready_s) state_s = ST_WRITE;
                else              state_s = ST_PAYLOAD;
            end
            ST_WRITE: begin
                if (!last_s) begin
                    state_s = ST_PAYLOAD;
                end else begin
`ifdef LOADER_CHECKSUM_EN
                    state_s = ST_CHECK;
`else
                    state_s = ST_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept_s) state_s = (RX_DATA == csum_r) ? ST_DONE : ST_ERROR;
                else          state_s = ST_CHECK;
            end
`endif
            ST_DONE, ST_ERROR: begin
                if (START) state_s = ST_HEADER;
                else       state_s = state_r;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Word count, write index and checksum accumulator
    always_ff @(posedge CLK) begin
        if (!RST) begin
            idx_r  <= {AW{1'b0}};
            n_r    <= {(AW + 1){1'b0}};
`ifdef LOADER_CHECKSUM_EN
            csum_r <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (START) idx_r <= {AW{1'b0}};
                end
                ST_HEADER: begin
                    if (accept_s && !hdr_bad_s) begin
                        n_r   <= RX_DATA[AW:0];
                        idx_r <= {AW{1'b0}};
`ifdef LOADER_CHECKSUM_EN
                        csum_r <= RX_DATA;
`endif
                    end
                end
                ST_PAYLOAD: begin
`ifdef LOADER_CHECKSUM_EN
                    if (accept_s) csum_r <= csum_r ^ RX_DATA;
`endif
                end
                // The index stays on the last word so DONE/CHECK keep pointing at written data
                ST_WRITE: begin
                    if (!last_s) idx_r <= idx_r + {{(AW - 1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

    // Control outputs registered from the upcoming state so they align with it
    always_ff @(posedge CLK) begin
        if (!RST) begin
            rx_ready_r <= 1'b0;
            w_en_r     <= 1'b0;
            r_en_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            rx_ready_r <= (state_s == ST_HEADER) || (state_s == ST_PAYLOAD) || (state_s == ST_CHECK);
            w_en_r     <= (state_s == ST_WRITE) || (state_s == ST_CHECK);
            r_en_r     <= (state_s == ST_DONE);
            busy_r     <= (state_s == ST_HEADER) || (state_s == ST_PAYLOAD) ||
                          (state_s == ST_WRITE)  || (state_s == ST_CHECK);
            done_r     <= (state_s == ST_DONE);
            error_r    <= (state_s == ST_ERROR);
        end
    end

    assign RX_READY      = rx_ready_r;
    assign W_EN          = w_en_r;
    assign R_EN          = r_en_r;
    assign BUSY          = busy_r;
    assign DONE          = done_r;
    assign ERROR         = error_r;
    assign ADDRESS       = idx_r;
    assign W_INSTRUCTION = word_s;

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: expected ROM writes are queued as images are sent,
// a monitor pops them on each write pulse, and a ROM model checks the final image.
module tb_rom_loader;

    localparam int AB  = 4;
    localparam int CAP = 32;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  RX_DATA = 8'd0;
    logic        RX_VALID = 1'b0;
    logic        RX_READY, W_EN, R_EN, BUSY, DONE, ERROR;
    logic [31:0] W_INSTRUCTION;
    logic [AB:0] ADDRESS;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [AB:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] rom [0:CAP-1];
    logic [31:0] img [0:CAP-1];
    bit          ren_seen;

    rom_loader #(.ADDRESS_BITS(AB)) dut (
        .CLK(CLK), .RST(RST), .START(START), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RX_READY(RX_READY), .W_EN(W_EN), .W_INSTRUCTION(W_INSTRUCTION), .ADDRESS(ADDRESS),
        .R_EN(R_EN), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    always #5 CLK = ~CLK;

    // ROM behaviour: write on W_EN, otherwise zero the addressed slot unless reading
    always @(posedge CLK) begin
        if (W_EN) rom[ADDRESS] <= W_INSTRUCTION;
        else if (!R_EN) rom[ADDRESS] <= 32'd0;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a write cycle is W_EN high with RX_READY low; compare it to the scoreboard head
    always @(negedge CLK) begin
        if (R_EN) ren_seen = 1'b1;
        if (W_EN) check("no_wen_with_ren", {63'd0, R_EN}, 64'd0);
`ifndef LOADER_CHECKSUM_EN
        if (W_EN) check("rx_ready_low_in_write", {63'd0, RX_READY}, 64'd0);
`endif
        if (W_EN && !RX_READY) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h expected no write", ADDRESS, W_INSTRUCTION);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", {59'd0, ADDRESS}, {59'd0, e.addr});
                check("write_data", {32'd0, W_INSTRUCTION}, {32'd0, e.data});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_outputs"}, {57'd0, RX_READY, W_EN, R_EN, BUSY, DONE, ERROR, 1'b0}, 64'd0);
        check({tag, "_address"}, {59'd0, ADDRESS}, 64'd0);
        check({tag, "_winstr"}, {32'd0, W_INSTRUCTION}, 64'd0);
    endtask

    task automatic pulse_start();
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle before every byte, 2 random idle cycles
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        int t;
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
            RX_VALID = 1'b0;
            RX_DATA  = 8'($urandom);
            @(negedge CLK);
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        t = 0;
        while (!RX_READY && t < 50) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 50) check("rx_ready_timeout", 64'd0, 64'd1);
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    // Sends header n (plus payload from img when n is legal) and checks the outcome
    task automatic load(input int n, input int gap_mode, input bit corrupt_cs, input bit exp_done);
        logic [7:0]  cs;
        logic [7:0]  b;
        int          t;
        pulse_start();
        ren_seen = 1'b0;
        check("header_busy_ready", {62'd0, BUSY, RX_READY}, 64'd3);
        cs = n[7:0];
        send_byte(n[7:0], gap_mode);
        if (n >= 1 && n <= CAP) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{addr: i[AB:0], data: img[i]});
                for (int j = 0; j < 4; j++) begin
                    b  = 8'((img[i] >> (8 * j)) & 32'hff);
                    cs = cs ^ b;
                    send_byte(b, gap_mode);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(corrupt_cs ? (cs ^ 8'h01) : cs, gap_mode);
`endif
        end
        t = 0;
        while (!(DONE || ERROR) && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (t >= 200) check("end_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge CLK);
        check("done_flag", {63'd0, DONE}, {63'd0, exp_done});
        check("error_flag", {63'd0, ERROR}, {63'd0, !exp_done});
        check("r_en", {63'd0, R_EN}, {63'd0, exp_done});
        check("busy_low", {63'd0, BUSY}, 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        if (exp_done) begin
            check("done_address", {59'd0, ADDRESS}, 64'(n - 1));
            for (int i = 0; i < n; i++) check("rom_image", {32'd0, rom[i]}, {32'd0, img[i]});
        end else begin
            check("r_en_never_rose", {63'd0, ren_seen}, 64'd0);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < CAP; i++) rom[i] = 32'd0;

        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check_all_zero("idle");

        img[0] = 32'h00000513;
        img[1] = 32'h00100593;
        load(2, 0, 1'b0, 1'b1);

        load(0, 0, 1'b0, 1'b0);
        load(33, 0, 1'b0, 1'b0);
        load($urandom_range(34, 255), 2, 1'b0, 1'b0);

        load(2, 1, 1'b0, 1'b1);

        // Reset in the middle of a word
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check_all_zero("midload_reset");
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK);
        load(2, 0, 1'b0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
        img[0] = 32'h00000013;
        load(1, 0, 1'b0, 1'b1);
        RST = 1'b0;
        @(negedge CLK) RST = 1'b1;
        @(negedge CLK);
        load(1, 0, 1'b1, 1'b0);
`endif

        // Full-capacity image, then confirm DONE holds the last address and word 0 survives
        for (int i = 0; i < CAP; i++) img[i] = $urandom;
        load(CAP, 2, 1'b0, 1'b1);
        repeat (5) @(negedge CLK);
        check("full_hold_address", {59'd0, ADDRESS}, 64'd31);
        check("full_word0_intact", {32'd0, rom[0]}, {32'd0, img[0]});

        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, CAP);
            for (int i = 0; i < CAP; i++) img[i] = $urandom;
            load(n, 2, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
